// File: rtl/mem_responder.sv
// Word-granular backing-memory responder for cache line fills and write-through stores.
// Optional random ready stalls are enabled with `define MEM_RAND_STALL_EN.
module mem_responder #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 4,
   parameter int MAX_OUT = 2,
   parameter int GAP     = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_mem_ready,
   input  logic [31:0] i_mem_addr,
   input  logic        i_mem_ren,
   input  logic        i_mem_wen,
   input  logic [31:0] i_mem_wdata,
   output logic [31:0] o_mem_rdata,
   output logic        o_mem_valid
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
   localparam logic [GW-1:0] GAP_C     = GW'(GAP);

   logic [31:0]       r_mem [2**ADDR_W];
   logic [CW-1:0]     r_out_cnt;
   logic [GW-1:0]     r_gap_cnt;
   logic [LATENCY-1:0] r_vld;
   logic [31:0]       r_pdata [LATENCY];

   logic [ADDR_W-1:0] w_idx;
   logic              w_unused_addr;
   logic              w_stall;
   logic              w_ready;
   logic              w_acc;
   logic              w_wr_acc;
   logic              w_rd_acc;
   logic              w_ret;

   assign w_idx         = i_mem_addr[ADDR_W+1:2];
   assign w_unused_addr = ^{i_mem_addr[31:ADDR_W+2], i_mem_addr[1:0]};

`ifdef MEM_RAND_STALL_EN
   logic [15:0] r_lfsr;

   // Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      end
   end

   assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
   assign w_stall = 1'b0;
`endif

   assign w_ready  = !i_rst && (r_out_cnt < MAX_OUT_C) && (r_gap_cnt == '0) && !w_stall;
   assign w_acc    = (i_mem_ren || i_mem_wen) && w_ready;
   // a simultaneous read is dropped in favour of the write
   assign w_wr_acc = w_acc && i_mem_wen;
   assign w_rd_acc = w_acc && i_mem_ren && !i_mem_wen;
   assign w_ret    = r_vld[LATENCY-1];

   always_ff @(posedge i_clk) begin
      if (w_wr_acc) begin
         r_mem[w_idx] <= i_mem_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_out_cnt <= '0;
         r_gap_cnt <= '0;
      end else begin
         case ({w_rd_acc, w_ret})
            2'b10:   r_out_cnt <= r_out_cnt + CW'(1);
            2'b01:   r_out_cnt <= r_out_cnt - CW'(1);
            default: r_out_cnt <= r_out_cnt;
         endcase
         if (w_acc) begin
            r_gap_cnt <= GAP_C;
         end else if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
         end
      end
   end

   // stage 0 samples the array before any write landing on the same edge
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vld <= '0;
         for (int unsigned i = 0; i < LATENCY; i++) begin
            r_pdata[i] <= '0;
         end
      end else begin
         r_vld[0] <= w_rd_acc;
         if (w_rd_acc) begin
            r_pdata[0] <= r_mem[w_idx];
         end
         for (int unsigned i = 1; i < LATENCY; i++) begin
            r_vld[i]   <= r_vld[i-1];
            r_pdata[i] <= r_pdata[i-1];
         end
      end
   end

   assign o_mem_ready = w_ready;
   assign o_mem_valid = r_vld[LATENCY-1];
   assign o_mem_rdata = r_pdata[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: randomized and directed traffic against a word-array model.
module tb_mem_responder;

   localparam int LAT  = 4;
   localparam int MAXO = 2;
   localparam int GAPC = 1;
   localparam int AW   = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        ren;
   logic        wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        valid;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_W (AW),
      .LATENCY(LAT),
      .MAX_OUT(MAXO),
      .GAP    (GAPC)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .o_mem_ready(ready),
      .i_mem_addr (addr),
      .i_mem_ren  (ren),
      .i_mem_wen  (wen),
      .i_mem_wdata(wdata),
      .o_mem_rdata(rdata),
      .o_mem_valid(valid)
   );

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [4096];
   int          cyc      = 0;
   int          last_acc = -100;
   int          n_cmp    = 0;
   int          n_err    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // monitor: ready expectation from outstanding count and time since last accept
   initial begin : monitor
      exp_t e;
      logic exp_rdy;
      forever begin
         @(negedge clk);
         exp_rdy = !rst && (sb.size() < MAXO) && ((cyc - last_acc) > GAPC);
`ifdef MEM_RAND_STALL_EN
         n_cmp++;
         if (ready && !exp_rdy) begin
            n_err++;
            $display("FAIL ready_allowed: got %b, expected 0 (cycle %0d)", ready, cyc);
         end
`else
         check("ready", {31'd0, ready}, {31'd0, exp_rdy});
`endif
         if (valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_valid: got valid=1 rdata=%h, expected no response (cycle %0d)", rdata, cyc);
            end else begin
               e = sb.pop_front();
               check("rdata", rdata, e.data);
               check("resp_cycle", cyc, e.due);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      bit          got;
      int          acc;
      logic [11:0] wi;
      got   = 0;
      ren   = r;
      wen   = w;
      addr  = a;
      wdata = d;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (ready) got = 1;
      end
      if (!got) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: got ready=0 for 200 cycles, expected accept of addr %h", a);
         ren = 1'b0;
         wen = 1'b0;
         @(posedge clk);
         #1;
         return;
      end
      acc = cyc;
      @(posedge clk);
      #1;
      last_acc = acc;
      wi = a[13:2];
      if (w) model[wi] = d;
      else if (r) sb.push_back('{model[wi], acc + LAT});
      ren = 1'b0;
      wen = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d responses outstanding, expected 0", sb.size());
      end
   endtask

   initial begin : stim
      int          nrand;
      int          sel;
      logic [31:0] a;
      rst   = 1'b1;
      ren   = 1'b0;
      wen   = 1'b0;
      addr  = '0;
      wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_rdata", rdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 128; i++) req(1'b0, 1'b1, 32'(i * 4), $urandom);

      // write then read back, gap after write
      req(1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
      @(negedge clk);
      check("gap_after_write", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      req(1'b1, 1'b0, 32'h40, '0);
      drain();

      // line fill: in-order responses, cap on outstanding
      for (int i = 0; i < 4; i++) req(1'b1, 1'b0, 32'h100 + 32'(i * 4), '0);
      drain();

      req(1'b0, 1'b1, 32'h20, 32'h11111111);
      req(1'b1, 1'b0, 32'h20, '0);
      drain();

      // ren+wen together: write only, no response
      req(1'b1, 1'b1, 32'h30, 32'h5A5A5A5A);
      idle(8);
      req(1'b1, 1'b0, 32'h30, '0);
      drain();

      // reset with reads in flight
      req(1'b1, 1'b0, 32'h100, '0);
      req(1'b1, 1'b0, 32'h104, '0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      last_acc = -100;
      idle(8);
      req(1'b1, 1'b0, 32'h40, '0);
      drain();

      // upper address bits alias
      req(1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
      req(1'b1, 1'b0, 32'h4000, '0);
      drain();

`ifdef MEM_RAND_STALL_EN
      nrand = 1000;
`else
      nrand = 300;
`endif
      for (int n = 0; n < nrand; n++) begin
         sel = int'($urandom_range(0, 9));
         a   = ($urandom << 14) | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
         if (sel < 6)      req(1'b1, 1'b0, a, '0);
         else if (sel < 9) req(1'b0, 1'b1, a, $urandom);
         else              req(1'b1, 1'b1, a, $urandom);
         idle(int'($urandom_range(0, 2)));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
